// File: rtl/ap_ctrl_sequencer.sv
// ============================================================================
// Module      : ap_ctrl_sequencer
// Description : Batch sequencer for an ap_ctrl_hs kernel. It measures the
//               latency of each invocation and buffers the samples in a FWFT
//               FIFO. Optional watchdog: define AP_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ap_ctrl_sequencer #(
    parameter int CNT_W      = 16,
    parameter int LAT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] num_txn,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic             batch_done,
    output logic [CNT_W-1:0] txn_cnt,
    input  logic             lat_rd,
    output logic [LAT_W-1:0] lat_dout,
    output logic             lat_empty,
    output logic             lat_full,
    output logic             lat_ovf,
    output logic             timeout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("ap_ctrl_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             ap_start_q, ap_start_d;
    logic             busy_q, busy_d;
    logic             batch_done_q, batch_done_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [LAT_W-1:0] mem_q [FIFO_DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_launch;
    logic             w_accept;
    logic             w_wd_expire;
    logic [CNT_W-1:0] w_txn_inc;

    assign w_txn_inc = txn_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        ap_start_d   = ap_start_q;
        busy_d       = busy_q;
        batch_done_d = 1'b0;
        txn_cnt_d    = txn_cnt_q;
        num_d        = num_q;
        lat_cnt_d    = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);
        w_push       = 1'b0;
        w_launch     = 1'b0;
        w_accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    w_accept  = 1'b1;
                    txn_cnt_d = '0;
                    num_d     = num_txn;
                    busy_d    = 1'b1;
                    if (num_txn != '0) begin
                        state_d    = S_START;
                        ap_start_d = 1'b1;
                        w_launch   = 1'b1;
                    end else begin
                        state_d      = S_FINISH;
                        batch_done_d = 1'b1;
                    end
                end
            end
            S_START, S_WAIT_DONE: begin
                // A done in the handshake cycle completes the invocation at once
                if (ap_done && (state_q == S_WAIT_DONE || ap_ready)) begin
                    w_push    = 1'b1;
                    txn_cnt_d = w_txn_inc;
                    if (w_txn_inc == num_q) begin
                        state_d      = S_FINISH;
                        ap_start_d   = 1'b0;
                        batch_done_d = 1'b1;
                    end else begin
                        state_d    = S_START;
                        ap_start_d = 1'b1;
                        w_launch   = 1'b1;
                    end
                end else if (state_q == S_START && ap_ready) begin
                    state_d    = S_WAIT_DONE;
                    ap_start_d = 1'b0;
                end else if (w_wd_expire) begin
                    state_d      = S_FINISH;
                    ap_start_d   = 1'b0;
                    batch_done_d = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                ap_start_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        if (w_launch) begin
            lat_cnt_d = LAT_W'(1);
        end
    end

    // Sample FIFO: a pop frees the slot, so push and pop together on full both succeed
    assign lat_empty = (rd_ptr_q == wr_ptr_q);
    assign lat_full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign w_pop     = lat_rd && !lat_empty;
    assign w_wr      = w_push && (!lat_full || w_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_pop};
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_wr};
        ovf_d    = ovf_q;
        if (w_accept) begin
            ovf_d = 1'b0;
        end else if (w_push && !w_wr) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            ap_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            txn_cnt_q    <= '0;
            num_q        <= '0;
            lat_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            ap_start_q   <= ap_start_d;
            busy_q       <= busy_d;
            batch_done_q <= batch_done_d;
            txn_cnt_q    <= txn_cnt_d;
            num_q        <= num_d;
            lat_cnt_q    <= lat_cnt_d;
            ovf_q        <= ovf_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= lat_cnt_q;
        end
    end

`ifdef AP_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            w_wd_active;

    // The watchdog restarts with every invocation
    assign w_wd_active = (state_q == S_START) || (state_q == S_WAIT_DONE);
    assign w_wd_expire = w_wd_active && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (w_launch) begin
            wd_d = '0;
        end else if (w_wd_active && !w_wd_expire) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (w_accept) begin
            timeout_d = 1'b0;
        end else if (w_wd_expire && (state_d == S_FINISH) && !w_push) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign ap_start   = ap_start_q;
    assign busy       = busy_q;
    assign batch_done = batch_done_q;
    assign txn_cnt    = txn_cnt_q;
    assign lat_ovf    = ovf_q;
    assign lat_dout   = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_sequencer.sv
// ============================================================================
// Module      : tb_ap_ctrl_sequencer
// Description : Self-checking bench for ap_ctrl_sequencer with a kernel model
//               and a latency-sample scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ap_ctrl_sequencer;

    localparam int CNT_W      = 16;
    localparam int LAT_W      = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 20;
    localparam int BUDGET     = 2000;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             run;
    logic [CNT_W-1:0] num_txn;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             busy;
    logic             batch_done;
    logic [CNT_W-1:0] txn_cnt;
    logic             lat_rd;
    logic [LAT_W-1:0] lat_dout;
    logic             lat_empty;
    logic             lat_full;
    logic             lat_ovf;
    logic             timeout;

    int n_checks = 0;
    int n_errors = 0;

    // kernel model state
    int          k_ready_dly = 0;
    int          k_done_dly  = 0;
    bit          k_never_done = 1'b0;
    bit          k_active = 1'b0;
    bit          k_ready_seen = 1'b0;
    int          k_cyc = 0;
    int          k_inv = 0;
    int          overlap_errs = 0;
    logic [31:0] k_exp_val = '0;

    // scoreboard
    logic [31:0] exp_q[$];
    bit          model_ovf = 1'b0;
    int          bd_cnt = 0;

    ap_ctrl_sequencer #(
        .CNT_W      (CNT_W),
        .LAT_W      (LAT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .run        (run),
        .num_txn    (num_txn),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .busy       (busy),
        .batch_done (batch_done),
        .txn_cnt    (txn_cnt),
        .lat_rd     (lat_rd),
        .lat_dout   (lat_dout),
        .lat_empty  (lat_empty),
        .lat_full   (lat_full),
        .lat_ovf    (lat_ovf),
        .timeout    (timeout)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Kernel: ready/done at fixed offsets from the first ap_start cycle
    initial begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                k_active = 1'b0;
                ap_ready = 1'b0;
                ap_done  = 1'b0;
            end else begin
                if (ap_done) k_active = 1'b0;
                ap_ready = 1'b0;
                ap_done  = 1'b0;
                if (ap_start && k_active && k_ready_seen) overlap_errs++;
                if (ap_start && !k_active) begin
                    k_active     = 1'b1;
                    k_ready_seen = 1'b0;
                    k_cyc        = 0;
                    k_inv++;
                end
                if (k_active) begin
                    if (k_cyc == k_ready_dly) begin
                        ap_ready     = 1'b1;
                        k_ready_seen = 1'b1;
                    end
                    if (!k_never_done && k_cyc == k_done_dly) begin
                        ap_done   = 1'b1;
                        k_exp_val = 32'(k_cyc + 1);
                    end
                    k_cyc++;
                end
            end
        end
    end

    // Reference FIFO: pop before push so a full FIFO accepts both in one cycle
    initial forever begin
        @(posedge ap_clk);
        if (!ap_rst_n) begin
            exp_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (run) model_ovf = 1'b0;
            if (lat_rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ap_done) begin
                if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(k_exp_val);
                else model_ovf = 1'b1;
            end
        end
    end

    initial forever begin
        @(posedge ap_clk);
        #1;
        if (batch_done) bd_cnt++;
    end

    task automatic start_batch(input int n, input int rdly, input int ddly, input bit never);
        k_ready_dly  = rdly;
        k_done_dly   = ddly;
        k_never_done = never;
        num_txn      = CNT_W'(n);
        run          = 1'b1;
        @(negedge ap_clk);
        run          = 1'b0;
    endtask

    task automatic wait_batch_done(output int waited);
        bit found = 1'b0;
        waited = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (batch_done) begin
                found = 1'b1;
                break;
            end
            @(negedge ap_clk);
            waited++;
        end
        if (!found) check("batch_done_wait", 0, 1);
    endtask

    task automatic run_batch(input int n, input int rdly, input int ddly, output int waited);
        int bd0 = bd_cnt;
        start_batch(n, rdly, ddly, 1'b0);
        wait_batch_done(waited);
        check("txn_cnt_end", txn_cnt, n);
        check("ap_start_end", ap_start, 0);
        check("busy_finish", busy, 1);
        @(negedge ap_clk);
        check("batch_done_width", batch_done, 0);
        check("busy_idle", busy, 0);
        check("batch_done_count", bd_cnt - bd0, 1);
    endtask

    task automatic read_samples(input int cnt);
        logic [31:0] exp_v;
        for (int i = 0; i < cnt; i++) begin
            check("lat_empty_rd", lat_empty, 0);
            check("sb_has_entry", exp_q.size() > 0, 1);
            exp_v = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
            check("lat_dout", lat_dout, exp_v);
            lat_rd = 1'b1;
            @(negedge ap_clk);
            lat_rd = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ap_start"}, ap_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_batch_done"}, batch_done, 0);
        check({tag, "_txn_cnt"}, txn_cnt, 0);
        check({tag, "_lat_empty"}, lat_empty, 1);
        check({tag, "_lat_full"}, lat_full, 0);
        check({tag, "_lat_ovf"}, lat_ovf, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    initial begin
        int w;
        int inv0;
        int bd0;
        bit found;
        ap_rst_n = 1'b0;
        run      = 1'b0;
        num_txn  = '0;
        lat_rd   = 1'b0;
        repeat (3) @(negedge ap_clk);
        check_reset_values("por");
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // three invocations, ready after 1 cycle, done 4 cycles after start
        run_batch(3, 1, 4, w);
        check("sb_count_3", exp_q.size(), 3);
        read_samples(3);
        check("empty_after_3", lat_empty, 1);

        // ready and done in the first ap_start cycle
        run_batch(1, 0, 0, w);
        check("same_cycle_bd_lat", w, 1);
        read_samples(1);

        // empty batch
        inv0 = k_inv;
        run_batch(0, 0, 0, w);
        check("zero_bd_lat", w, 0);
        check("zero_no_start", k_inv - inv0, 0);

        // overflow: ten samples into an eight-deep FIFO
        run_batch(10, 1, 2, w);
        check("ovf_full", lat_full, 1);
        check("ovf_flag", lat_ovf, model_ovf);
        check("ovf_flag_set", lat_ovf, 1);

        // push and pop together while full
        start_batch(1, 0, 0, 1'b0);
        check("pp_dout", lat_dout, exp_q[0]);
        lat_rd = 1'b1;
        @(negedge ap_clk);
        lat_rd = 1'b0;
        wait_batch_done(w);
        check("pp_full", lat_full, 1);
        check("pp_ovf", lat_ovf, model_ovf);
        @(negedge ap_clk);
        read_samples(FIFO_DEPTH);
        check("pp_empty", lat_empty, 1);

        // kernel that never completes
        bd0 = bd_cnt;
        start_batch(2, 1, 0, 1'b1);
`ifdef AP_SEQ_TIMEOUT_EN
        wait_batch_done(w);
        check("wd_cycles", w, TIMEOUT);
        check("wd_timeout", timeout, 1);
        check("wd_txn_cnt", txn_cnt, 0);
        check("wd_ap_start", ap_start, 0);
`else
        repeat (100) @(negedge ap_clk);
        check("hang_busy", busy, 1);
        check("hang_timeout", timeout, 0);
        check("hang_no_bd", bd_cnt - bd0, 0);
`endif
        do_reset();
        k_never_done = 1'b0;

        // reset during the wait of the second invocation
        bd0  = bd_cnt;
        inv0 = k_inv;
        found = 1'b0;
        start_batch(3, 1, 4, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            #2;
            if (k_inv == inv0 + 2 && k_cyc == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reach_wait", found, 1);
        ap_rst_n = 1'b0;
        #1;
        check_reset_values("mid");
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) @(negedge ap_clk);
        check("mid_no_bd", bd_cnt - bd0, 0);

        run_batch(2, 2, 5, w);
        read_samples(2);
        check("final_empty", lat_empty, 1);
        check("no_overlap", overlap_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ap_ctrl_sequencer.md
AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of transaction count and counters.
REQ-002 SHALL have parameter LAT_W, default 32, width of the per-transaction latency sample.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two), latency sample buffer depth.
REQ-004 SHALL have parameter TIMEOUT, default 65535, watchdog limit in cycles (used only with AP_SEQ_TIMEOUT_EN).
REQ-005 SHALL have port ap_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port run  in  1  one-cycle pulse, starts a batch.
REQ-008 SHALL have port num_txn  in  CNT_W  kernel invocations per batch, sampled on run.
REQ-009 SHALL have ports ap_start out 1, ap_ready in 1, ap_done in 1: ap_ctrl_hs handshake to kernel.
REQ-010 SHALL have port busy  out  1  high while a batch is in progress.
REQ-011 SHALL have port batch_done  out  1  one-cycle pulse at batch end.
REQ-012 SHALL have port txn_cnt  out  CNT_W  completed invocations in current/last batch.
REQ-013 SHALL have ports lat_rd in 1, lat_dout out LAT_W, lat_empty out 1, lat_full out 1: latency sample FIFO read side.
REQ-014 SHALL have port lat_ovf  out  1  sticky, a sample was dropped on full FIFO.
REQ-015 SHALL have port timeout  out  1  sticky watchdog flag.

Function
REQ-016 SHALL implement FSM IDLE, START, WAIT_DONE, FINISH.
REQ-017 IDLE: run=1 and num_txn!=0 -> START, latch num_txn, clear txn_cnt, lat_ovf, timeout; run with num_txn=0 -> FINISH directly; run outside IDLE ignored.
REQ-018 START: ap_start=1, held until ap_ready=1; ap_ready -> ap_start drops next cycle, go to WAIT_DONE (or count completion immediately if ap_done also 1 that cycle).
REQ-019 WAIT_DONE: ap_done=1 -> txn_cnt+1, push sample; if txn_cnt+1==latched num_txn -> FINISH else START on next cycle.
REQ-020 Invocations SHALL NOT overlap: ap_start never asserted while a prior invocation lacks ap_done.
REQ-021 Latency counter SHALL reset to 1 on the first ap_start cycle of each invocation and increment each cycle; sample = value in the ap_done cycle; saturates at all-ones.
REQ-022 FINISH: batch_done=1 for exactly one cycle, then IDLE; busy=1 in START/WAIT_DONE/FINISH.
REQ-023 FIFO SHALL be first-word-fall-through; lat_dout valid whenever lat_empty=0; lat_rd on empty ignored.
REQ-024 Push on full SHALL drop the new sample and set lat_ovf; simultaneous push and pop on full SHALL accept both.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; contents persist across batches until read.
REQ-026 ap_done/ap_ready outside START/WAIT_DONE SHALL be ignored.

Reset
REQ-027 ap_rst_n=0 SHALL immediately force IDLE, ap_start=0, busy=0, batch_done=0, txn_cnt=0, lat_ovf=0, timeout=0, FIFO empty (lat_empty=1, lat_full=0).
REQ-028 Reset mid-batch SHALL abandon the batch with no batch_done pulse; first run after release is accepted.

Configuration
REQ-029 With AP_SEQ_TIMEOUT_EN defined: a cycle counter in START/WAIT_DONE reaching TIMEOUT SHALL set timeout, drop ap_start, and go to FINISH (batch_done pulses; txn_cnt holds completed count).
REQ-030 Without AP_SEQ_TIMEOUT_EN: no watchdog logic, timeout tied 0, FSM waits indefinitely.

Verification
REQ-031 num_txn=3, kernel ap_ready 1 cycle after start, ap_done 4 cycles later -> 3 samples each 5, txn_cnt=3, one batch_done, ap_start never high while awaiting ap_done.
REQ-032 ap_ready and ap_done same cycle as first ap_start -> sample=1, ap_start low next cycle.
REQ-033 num_txn=10, lat_rd held 0, FIFO_DEPTH=8 -> lat_full=1 after 8th, lat_ovf=1, 8 samples readable in order.
REQ-034 Assert ap_rst_n=0 in WAIT_DONE of 2nd invocation -> all outputs at reset values same cycle, no batch_done; new run completes normally.
REQ-035 AP_SEQ_TIMEOUT_EN, TIMEOUT=20, kernel never raises ap_done -> timeout=1 and batch_done after 20 cycles, txn_cnt=0; without macro, busy stays 1.
REQ-036 run with num_txn=0 -> batch_done pulse 1 cycle later, ap_start never asserted, txn_cnt=0.
